irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_irq_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Six-source prioritised interrupt controller with a memory-mapped MASK/PENDING/EOI/STATUS block.
// Define IRQ_CTRL_NEST_EN to allow one level of nesting by a higher-priority source.

module irq_src_cell (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic clr,
  output logic pend
);
  logic prev;

  // A rising edge sets the bit even when a clear lands in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 1'b0;
      pend <= 1'b0;
    end else begin
      prev <= irq;
      pend <= (irq & ~prev) | (pend & ~clr);
    end
  end
endmodule

module irq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:2]  addr,
  input  logic        WE,
  input  logic [31:0] DATA_in,
  output logic [31:0] DATA_out,
  input  logic [5:0]  hw_irq,
  output logic        int_req,
  output logic [2:0]  int_id,
  input  logic        int_ack
);
  localparam int         NUM_SRC = 6;
  localparam logic [2:0] NO_ID   = 3'd7;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;

  state_t               state;
  logic [NUM_SRC-1:0]   mask, pending, eligible, clr, ack_clr;
  logic [2:0]           inservice_id, nested_id, winner;
  logic                 depth, any_elig, mask_we, pend_we, eoi, ack_take, nest_ok;
  logic                 unused_data;

  assign unused_data = ^DATA_in[31:NUM_SRC];
  assign mask_we     = WE && (addr == 2'd0);
  assign pend_we     = WE && (addr == 2'd1);
  assign eoi         = WE && (addr == 2'd2) && (state == SERVICE);
  assign eligible    = pending & mask;

`ifdef IRQ_CTRL_NEST_EN
  assign ack_take = int_ack && ((state == REQ) || (state == SERVICE && int_req && !eoi));
  assign nest_ok  = any_elig && (winner < inservice_id) && !depth;
`else
  assign ack_take = int_ack && (state == REQ);
  assign nest_ok  = 1'b0;
`endif

  always_comb begin
    winner   = '0;
    any_elig = |eligible;
    for (int i = NUM_SRC-1; i >= 0; i--)
      if (eligible[i]) winner = 3'(i);
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++)
      ack_clr[i] = ack_take && (int_id == 3'(i));
  end

  assign clr = (pend_we ? DATA_in[NUM_SRC-1:0] : '0) | ack_clr;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_src_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .irq   (hw_irq[g]),
      .clr   (clr[g]),
      .pend  (pending[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mask <= '0;
    else if (mask_we) mask <= DATA_in[NUM_SRC-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      int_req      <= 1'b0;
      int_id       <= '0;
      inservice_id <= NO_ID;
    end else begin
      case (state)
        IDLE:
          if (any_elig) begin
            state   <= REQ;
            int_req <= 1'b1;
            int_id  <= winner;
          end
        REQ:
          if (int_ack) begin
            state        <= SERVICE;
            int_req      <= 1'b0;
            inservice_id <= int_id;
          end else if (!any_elig) begin
            state   <= IDLE;
            int_req <= 1'b0;
          end else begin
            int_id <= winner;
          end
        SERVICE:
          if (eoi && !depth) begin
            state        <= IDLE;
            int_req      <= 1'b0;
            inservice_id <= NO_ID;
          end else if (eoi) begin
            inservice_id <= nested_id;
          end else if (ack_take) begin
            int_req      <= 1'b0;
            inservice_id <= int_id;
          end else begin
            // A nested request stays up only while a more urgent source is still waiting.
            int_req <= nest_ok;
            if (nest_ok) int_id <= winner;
          end
        default: begin
          state   <= IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef IRQ_CTRL_NEST_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nested_id <= NO_ID;
      depth     <= 1'b0;
    end else if (state == SERVICE) begin
      if (eoi && depth) begin
        nested_id <= NO_ID;
        depth     <= 1'b0;
      end else if (ack_take) begin
        nested_id <= inservice_id;
        depth     <= 1'b1;
      end
    end
  end
`else
  assign nested_id = NO_ID;
  assign depth     = 1'b0;
`endif

  always_comb begin
    DATA_out = '0;
    case (addr)
      2'd0: DATA_out = {26'b0, mask};
      2'd1: DATA_out = {26'b0, pending};
      2'd2: DATA_out = {29'b0, inservice_id};
      2'd3: DATA_out = {23'b0, depth, nested_id, inservice_id, state};
      default: DATA_out = '0;
    endcase
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed scenarios plus random traffic for irq_ctrl, checked against a rule-level reference model.
`timescale 1ns/1ps

module tb_irq_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:2]  addr = '0;
  logic        WE = 1'b0;
  logic [31:0] DATA_in = '0;
  logic [31:0] DATA_out;
  logic [5:0]  hw_irq = '0;
  logic        int_req;
  logic [2:0]  int_id;
  logic        int_ack = 1'b0;

  int errors = 0;
  int checks = 0;

`ifdef IRQ_CTRL_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  irq_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .WE       (WE),
    .DATA_in  (DATA_in),
    .DATA_out (DATA_out),
    .hw_irq   (hw_irq),
    .int_req  (int_req),
    .int_id   (int_id),
    .int_ack  (int_ack)
  );

  always #50 clk = ~clk;

  // Reference model state
  bit [5:0] m_mask, m_pend, m_prev;
  int       m_state, m_id, m_is, m_nest, m_depth;
  bit       m_req;

  function automatic int lowest(input bit [5:0] v);
    for (int i = 0; i < 6; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] status_w(input int d, input int n, input int i, input int s);
    return {23'b0, d[0], n[2:0], i[2:0], s[1:0]};
  endfunction

  task automatic model_reset();
    m_mask = '0; m_pend = '0; m_prev = '0;
    m_state = 0; m_req = 0; m_id = 0; m_is = 7; m_nest = 7; m_depth = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_next();
    bit [5:0] rise, clrv, n_pend;
    int w;
    bit eoi, ack_ok, can;
    rise = hw_irq & ~m_prev;
    w    = lowest(m_pend & m_mask);
    eoi  = WE && addr == 2'd2 && m_state == 2;
    clrv = (WE && addr == 2'd1) ? DATA_in[5:0] : 6'd0;
    ack_ok = (m_state == 1) && int_ack;
    if (NEST && m_state == 2 && m_req && int_ack && !eoi) ack_ok = 1;
    if (ack_ok) clrv[m_id] = 1'b1;
    n_pend = (m_pend & ~clrv) | rise;
    m_prev = hw_irq;
    if (WE && addr == 2'd0) m_mask = DATA_in[5:0];
    case (m_state)
      0: if (w >= 0) begin m_state = 1; m_req = 1; m_id = w; end
      1: if (ack_ok) begin m_state = 2; m_req = 0; m_is = m_id; end
         else if (w < 0) begin m_state = 0; m_req = 0; end
         else m_id = w;
      default:
        if (eoi && m_depth == 1) begin m_is = m_nest; m_nest = 7; m_depth = 0; end
        else if (eoi) begin m_state = 0; m_req = 0; m_is = 7; end
        else if (ack_ok) begin m_nest = m_is; m_is = m_id; m_depth = 1; m_req = 0; end
        else begin
          can = NEST && w >= 0 && w < m_is && m_depth == 0;
          m_req = can;
          if (can) m_id = w;
        end
    endcase
    m_pend = n_pend;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input int a, input logic [31:0] exp);
    addr = 2'(a);
    #1;
    chk(tag, DATA_out, exp);
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".req"}, 32'(int_req), 32'(m_req));
    if (m_req) chk({tag, ".id"}, 32'(int_id), 32'(m_id));
    chk_rd({tag, ".mask"}, 0, {26'b0, m_mask});
    chk_rd({tag, ".pend"}, 1, {26'b0, m_pend});
    chk_rd({tag, ".isv"},  2, 32'(m_is));
    chk_rd({tag, ".stat"}, 3, status_w(m_depth, m_nest, m_is, m_state));
  endtask

  task automatic tick(input string tag);
    model_next();
    @(posedge clk);
    #1;
    cmp_model(tag);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    addr = 2'(a); WE = 1'b1; DATA_in = d;
    tick("wr");
    WE = 1'b0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick("ack");
    int_ack = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst.req", 32'(int_req), 0);
    chk("rst.id", 32'(int_id), 0);
    chk_rd("rst.mask", 0, 0);
    chk_rd("rst.pend", 1, 0);
    chk_rd("rst.isv", 2, 7);
    chk_rd("rst.stat", 3, status_w(0, 7, 7, 0));
    model_reset();
    @(posedge clk); #1 reset = 1'b0;

    // Single source: pending one edge after the rise, request two edges after
    wr(0, 32'h3);
    hw_irq = 6'b000010;
    tick("s1a");
    chk_rd("s1.pend", 1, 32'h2);
    chk("s1.req0", 32'(int_req), 0);
    hw_irq = '0;
    tick("s1b");
    chk("s1.req", 32'(int_req), 1);
    chk("s1.id", 32'(int_id), 1);
    ack();
    chk_rd("s1.stat", 3, status_w(0, 7, 1, 2));
    wr(2, 32'h0);
    chk_rd("s1.eoi", 2, 32'h7);

    // Simultaneous rise: lower index wins
    hw_irq = 6'b000011;
    tick("s2a");
    hw_irq = '0;
    tick("s2b");
    chk("s2.id", 32'(int_id), 0);
    ack();
    chk_rd("s2.pend", 1, 32'h2);
    chk_rd("s2.stat", 3, status_w(0, 7, 0, 2));
    wr(2, 32'h0);
    tick("s2c");
    chk("s2.id1", 32'(int_id), 1);
    ack();
    wr(2, 32'h0);

    // Masking while requesting withdraws the request, pending survives
    hw_irq = 6'b000010;
    tick("s3a");
    hw_irq = '0;
    tick("s3b");
    wr(0, 32'h0);
    tick("s3c");
    chk("s3.req", 32'(int_req), 0);
    chk_rd("s3.stat", 3, status_w(0, 7, 7, 0));
    chk_rd("s3.pend", 1, 32'h2);
    wr(0, 32'h3);
    tick("s3d");
    chk("s3.rereq", 32'(int_req), 1);
    ack();
    wr(2, 32'h0);

    // Rise and write-1-to-clear on the same bit: set wins; masked edge still pends
    wr(0, 32'h0);
    hw_irq = 6'b000010; addr = 2'd1; WE = 1'b1; DATA_in = 32'h2;
    tick("s4a");
    WE = 1'b0; hw_irq = '0;
    chk_rd("s4.pend", 1, 32'h2);
    tick("s4b");
    chk("s4.masked", 32'(int_req), 0);
    wr(0, 32'h3);
    tick("s4c");
    chk("s4.unmask", 32'(int_req), 1);
    chk("s4.id", 32'(int_id), 1);
    ack();

    // Asynchronous reset while in service; a held source re-pends after release
    hw_irq = 6'b000100;
    tick("s5a");
    #5 reset = 1'b1;
    #1;
    chk("s5.req", 32'(int_req), 0);
    chk_rd("s5.isv", 2, 32'h7);
    chk_rd("s5.pend", 1, 32'h0);
    model_reset();
    @(posedge clk); #1 reset = 1'b0;
    tick("s5b");
    chk_rd("s5.held", 1, 32'h4);
    hw_irq = '0;
    wr(1, 32'h3f);

    // Nesting behaviour
    wr(0, 32'h3);
    hw_irq = 6'b000010;
    tick("s6a");
    hw_irq = '0;
    tick("s6b");
    ack();
    hw_irq = 6'b000001;
    tick("s6c");
    hw_irq = '0;
    tick("s6d");
    if (NEST) begin
      chk("s6.nreq", 32'(int_req), 1);
      chk("s6.nid", 32'(int_id), 0);
      ack();
      chk_rd("s6.stat", 3, status_w(1, 1, 0, 2));
      wr(2, 32'h0);
      chk_rd("s6.isv", 2, 32'h1);
      chk_rd("s6.stat2", 3, status_w(0, 7, 1, 2));
      wr(2, 32'h0);
      chk_rd("s6.idle", 3, status_w(0, 7, 7, 0));
    end else begin
      chk("s6.noreq", 32'(int_req), 0);
      chk_rd("s6.stat", 3, status_w(0, 7, 1, 2));
      wr(1, 32'h1);
      wr(2, 32'h0);
      chk_rd("s6.idle", 3, status_w(0, 7, 7, 0));
    end

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      hw_irq  = hw_irq ^ 6'($urandom & $urandom & $urandom);
      int_ack = ($urandom_range(0, 2) == 0);
      WE      = ($urandom_range(0, 5) == 0);
      addr    = 2'($urandom_range(0, 3));
      DATA_in = $urandom;
      tick("rnd");
    end
    WE = 1'b0; int_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
